// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // 0 = m0 (CPU load/store unit), 1 = m1 (debug/boot loader)
  typedef logic req_id_t;

  localparam int NUM_REQ = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: the requester that did not win last time has
// priority when both are requesting.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_id_t            rr_last,
  output logic [NUM_REQ-1:0] gnt
);

  assign gnt[0] = req[0] & (~req[1] | rr_last);
  assign gnt[1] = req[1] & (~req[0] | ~rr_last);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single dmem port between the CPU LSU (m0) and the debug/boot
// loader (m1) with round-robin arbitration and optional locked bursts.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DMEM_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         m0_req,
  input  logic                         m0_we,
  input  logic                         m0_lock,
  input  logic [DMEM_ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]        m0_wdata,
  input  logic [DATA_WIDTH/8-1:0]      m0_wstrb,
  output logic                         m0_gnt,
  output logic                         m0_rvalid,
  output logic [DATA_WIDTH-1:0]        m0_rdata,
  input  logic                         m1_req,
  input  logic                         m1_we,
  input  logic                         m1_lock,
  input  logic [DMEM_ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]        m1_wdata,
  input  logic [DATA_WIDTH/8-1:0]      m1_wstrb,
  output logic                         m1_gnt,
  output logic                         m1_rvalid,
  output logic [DATA_WIDTH-1:0]        m1_rdata,
  output logic [DMEM_ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_din,
  output logic [DATA_WIDTH/8-1:0]      mem_be,
  output logic                         mem_read,
  output logic                         mem_write,
  input  logic [DATA_WIDTH-1:0]        mem_dout
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  req_id_t             r_owner;
  req_id_t             w_owner_nxt;
  req_id_t             r_rr_last;
  req_id_t             r_rd_id;
  logic                r_rd_valid;

  logic [NUM_REQ-1:0]  w_req;
  logic [NUM_REQ-1:0]  w_lock;
  logic [NUM_REQ-1:0]  w_arb_gnt;
  logic [NUM_REQ-1:0]  w_gnt;
  req_id_t             w_gnt_id;
  logic                w_any_gnt;

  assign w_req  = {m1_req, m0_req};
  assign w_lock = {m1_lock, m0_lock};

  rr_arb2 u_rr_arb2 (
    .req     (w_req),
    .rr_last (r_rr_last),
    .gnt     (w_arb_gnt)
  );

  assign w_gnt_id  = w_gnt[1];
  assign w_any_gnt = |w_gnt;
  assign m0_gnt    = w_gnt[0];
  assign m1_gnt    = w_gnt[1];

  // Grant selection and next-state / next-owner decode
  always_comb begin
    w_gnt       = {NUM_REQ{1'b0}};
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    case (r_state)
      ARB_IDLE:   w_gnt = w_arb_gnt;
      ARB_LOCKED: w_gnt[r_owner] = w_req[r_owner];
      default:    w_gnt = {NUM_REQ{1'b0}};
    endcase
    // A granted beat decides the lock by its own lock bit; an idle owner
    // releases the lock by dropping it without issuing a beat.
    if (w_any_gnt) begin
      w_state_nxt = w_lock[w_gnt_id] ? ARB_LOCKED : ARB_IDLE;
      w_owner_nxt = w_gnt_id;
    end else if (r_state == ARB_LOCKED && !w_lock[r_owner]) begin
      w_state_nxt = ARB_IDLE;
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Memory-side mux driven by the granted requester
  always_comb begin
    mem_addr  = {DMEM_ADDR_WIDTH{1'b0}};
    mem_din   = {DATA_WIDTH{1'b0}};
    mem_be    = {STRB_WIDTH{1'b0}};
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (w_any_gnt) begin
      if (w_gnt_id) begin
        mem_addr  = m1_addr;
        mem_din   = m1_wdata;
        mem_be    = m1_wstrb;
        mem_read  = ~m1_we;
        mem_write = m1_we & (|m1_wstrb);
      end else begin
        mem_addr  = m0_addr;
        mem_din   = m0_wdata;
        mem_be    = m0_wstrb;
        mem_read  = ~m0_we;
        mem_write = m0_we & (|m0_wstrb);
      end
    end else begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

  // FSM, ownership, round-robin history and read-tag pipeline
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ARB_IDLE;
      r_owner    <= 1'b0;
      r_rr_last  <= 1'b1;
      r_rd_valid <= 1'b0;
      r_rd_id    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_rd_valid <= mem_read;
      r_rd_id    <= w_gnt_id;
      if (w_any_gnt) begin
        r_rr_last <= w_gnt_id;
      end else begin
        r_rr_last <= r_rr_last;
      end
    end
  end

  // dmem's registered output lines up with the tag captured at grant time
  assign m0_rvalid = r_rd_valid & ~r_rd_id;
  assign m1_rvalid = r_rd_valid &  r_rd_id;
  assign m0_rdata  = mem_dout;
  assign m1_rdata  = mem_dout;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: queued requester drivers, a
// 1-cycle-latency dmem model, and a transaction-level reference of the arbiter.
module tb_dmem_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SW = 4;

  typedef struct {
    bit            bubble;
    bit            we;
    bit            lock;
    bit [AW-1:0]   addr;
    bit [DW-1:0]   wdata;
    bit [SW-1:0]   wstrb;
  } beat_t;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } rexp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]    req = 2'b00;
  logic [1:0]    we = 2'b00;
  logic [1:0]    lock = 2'b00;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];
  logic [SW-1:0] wstrb [2];

  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [SW-1:0] mem_be;
  logic          mem_read, mem_write;
  logic [DW-1:0] mem_dout;

  dmem_port_arbiter #(.DMEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_req(req[0]), .m0_we(we[0]), .m0_lock(lock[0]), .m0_addr(addr[0]),
    .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(req[1]), .m1_we(we[1]), .m1_lock(lock[1]), .m1_addr(addr[1]),
    .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_be(mem_be),
    .mem_read(mem_read), .mem_write(mem_write), .mem_dout(mem_dout)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [DW-1:0] init_word(input int i);
    return (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
  endfunction

  // dmem environment: loads a known pattern while reset is high
  logic [DW-1:0] dmem [0:1023];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      for (int i = 0; i < 1024; i++) dmem[i] <= init_word(i);
      mem_dout <= '0;
    end else begin
      if (mem_write)
        for (int b = 0; b < SW; b++)
          if (mem_be[b]) dmem[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
      if (mem_read) mem_dout <= dmem[mem_addr];
    end
  end

  // requester drivers: present one beat from each queue, hold until granted
  beat_t    bq0[$];
  beat_t    bq1[$];
  bit [1:0] active = 2'b00;
  int       wait_cnt [2];
  initial begin
    logic [1:0] g;
    beat_t b;
    bit have;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    wstrb[0] = '0; wstrb[1] = '0;
    forever begin
      @(negedge clk);
      g = {m1_gnt, m0_gnt};
      @(posedge clk);
      #1;
      for (int n = 0; n < 2; n++) begin
        if (active[n] && g[n]) active[n] = 1'b0;
        if (reset) begin
          active[n] = 1'b0; req[n] = 1'b0; lock[n] = 1'b0;
        end else if (!active[n]) begin
          have = 1'b0;
          if (n == 0 && bq0.size() > 0) begin b = bq0.pop_front(); have = 1'b1; end
          if (n == 1 && bq1.size() > 0) begin b = bq1.pop_front(); have = 1'b1; end
          if (have) begin
            req[n] = !b.bubble; we[n] = b.we; lock[n] = b.lock; addr[n] = b.addr;
            wdata[n] = b.wdata; wstrb[n] = b.wstrb; active[n] = !b.bubble;
            wait_cnt[n] = 0;
          end else begin
            req[n] = 1'b0; lock[n] = 1'b0;
          end
        end else begin
          wait_cnt[n]++;
          if (wait_cnt[n] > 400) begin
            n_checks++;
            $display("FAIL grant_timeout: requester m%0d not granted after %0d cycles", n, wait_cnt[n]);
            active[n] = 1'b0; req[n] = 1'b0; lock[n] = 1'b0;
          end
        end
      end
    end
  end

  // reference arbiter + memory image, compared at every falling edge
  bit            m_locked;
  int            m_owner;
  int            m_last;
  int            eg;
  rexp_t         rq0[$];
  rexp_t         rq1[$];
  logic [DW-1:0] ref_mem [0:1023];
  always @(negedge clk) begin
    if (reset) begin
      m_locked = 1'b0; m_owner = 0; m_last = 1;
      rq0.delete(); rq1.delete();
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
      chk("rst_rvalid0", {31'd0, m0_rvalid}, 32'd0);
      chk("rst_rvalid1", {31'd0, m1_rvalid}, 32'd0);
    end else begin
      chk("m0_rvalid", {31'd0, m0_rvalid}, {31'd0, (rq0.size() > 0 && rq0[0].cyc == cyc)});
      if (m0_rvalid && rq0.size() > 0 && rq0[0].cyc == cyc) begin
        chk("m0_rdata", m0_rdata, rq0[0].data);
        void'(rq0.pop_front());
      end
      chk("m1_rvalid", {31'd0, m1_rvalid}, {31'd0, (rq1.size() > 0 && rq1[0].cyc == cyc)});
      if (m1_rvalid && rq1.size() > 0 && rq1[0].cyc == cyc) begin
        chk("m1_rdata", m1_rdata, rq1[0].data);
        void'(rq1.pop_front());
      end
      eg = -1;
      if (m_locked) begin
        if (req[m_owner]) eg = m_owner;
      end else if (req == 2'b11) eg = 1 - m_last;
      else if (req[0]) eg = 0;
      else if (req[1]) eg = 1;
      chk("m0_gnt", {31'd0, m0_gnt}, {31'd0, eg == 0});
      chk("m1_gnt", {31'd0, m1_gnt}, {31'd0, eg == 1});
      if (eg >= 0) begin
        chk("mem_read", {31'd0, mem_read}, {31'd0, !we[eg]});
        chk("mem_write", {31'd0, mem_write}, {31'd0, we[eg] && (wstrb[eg] != 4'd0)});
        chk("mem_addr", {22'd0, mem_addr}, {22'd0, addr[eg]});
        chk("mem_be", {28'd0, mem_be}, {28'd0, wstrb[eg]});
        if (we[eg]) begin
          chk("mem_din", mem_din, wdata[eg]);
          for (int b = 0; b < SW; b++)
            if (wstrb[eg][b]) ref_mem[addr[eg]][8*b +: 8] = wdata[eg][8*b +: 8];
        end else if (eg == 0) rq0.push_back('{ref_mem[addr[0]], cyc + 1});
        else rq1.push_back('{ref_mem[addr[1]], cyc + 1});
        m_last = eg; m_owner = eg; m_locked = lock[eg];
      end else begin
        chk("idle_mem_read", {31'd0, mem_read}, 32'd0);
        chk("idle_mem_write", {31'd0, mem_write}, 32'd0);
        chk("idle_mem_addr", {22'd0, mem_addr}, 32'd0);
        chk("idle_mem_be", {28'd0, mem_be}, 32'd0);
        if (m_locked && !lock[m_owner]) m_locked = 1'b0;
      end
    end
  end

  function automatic beat_t mk(input bit bub, input bit w, input bit lk, input int a,
                               input logic [DW-1:0] d, input logic [SW-1:0] s);
    beat_t b;
    b.bubble = bub; b.we = w; b.lock = lk; b.addr = AW'(a); b.wdata = d; b.wstrb = s;
    return b;
  endfunction

  task automatic drain();
    int k = 0;
    while ((bq0.size() > 0 || bq1.size() > 0 || active != 2'b00) && k < 5000) begin
      @(posedge clk);
      k++;
    end
    if (k >= 5000) begin
      n_checks++;
      $display("FAIL drain_timeout: requesters still busy after %0d cycles", k);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_gnt(input string name);
    int k = 0;
    @(negedge clk);
    while (!(m0_gnt || m1_gnt) && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      n_checks++;
      $display("FAIL %s: no grant within %0d cycles", name, k);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    repeat (2) @(posedge clk);

    // reset mid-operation while an m0 read return is pending
    bq0.push_back(mk(1'b0, 1'b0, 1'b0, 7, 32'd0, 4'hF));
    wait_gnt("pending_read_grant");
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("reset_drops_rvalid0", {31'd0, m0_rvalid}, 32'd0);
    chk("reset_drops_rvalid1", {31'd0, m1_rvalid}, 32'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);

    // first contention after reset: m0 wins, then alternate
    for (int i = 0; i < 3; i++) begin
      bq0.push_back(mk(1'b0, 1'b0, 1'b0, 5, 32'd0, 4'hF));
      bq1.push_back(mk(1'b0, 1'b0, 1'b0, 9, 32'd0, 4'hF));
    end
    wait_gnt("first_contention");
    chk("first_contention_m0", {31'd0, m0_gnt}, 32'd1);
    drain();

    // m1 locked write burst while m0 keeps requesting
    for (int i = 0; i < 4; i++)
      bq1.push_back(mk(1'b0, 1'b1, i < 3, i, 32'hA0 + 32'(i), 4'hF));
    @(posedge clk);
    bq0.push_back(mk(1'b0, 1'b0, 1'b0, 10, 32'd0, 4'hF));
    bq0.push_back(mk(1'b0, 1'b0, 1'b0, 0, 32'd0, 4'hF));
    drain();
    for (int i = 0; i < 4; i++) chk("burst_mem", dmem[i], 32'hA0 + 32'(i));

    // idle lock hold, then idle unlock
    bq1.push_back(mk(1'b0, 1'b1, 1'b1, 20, 32'h1234ABCD, 4'hF));
    bq1.push_back(mk(1'b1, 1'b0, 1'b1, 0, 32'd0, 4'h0));
    bq1.push_back(mk(1'b1, 1'b0, 1'b0, 0, 32'd0, 4'h0));
    @(posedge clk);
    bq0.push_back(mk(1'b0, 1'b0, 1'b0, 20, 32'd0, 4'hF));
    drain();

    // byte strobes and an all-zero strobe write
    bq0.push_back(mk(1'b0, 1'b1, 1'b0, 3, 32'd0, 4'hF));
    bq0.push_back(mk(1'b0, 1'b1, 1'b0, 3, 32'hDEADBEEF, 4'b0010));
    bq0.push_back(mk(1'b0, 1'b0, 1'b0, 3, 32'd0, 4'hF));
    drain();
    chk("strobe_mem", dmem[3], 32'h0000BE00);
    bq0.push_back(mk(1'b0, 1'b1, 1'b0, 3, 32'h12345678, 4'b0000));
    bq0.push_back(mk(1'b0, 1'b0, 1'b0, 3, 32'd0, 4'hF));
    drain();
    chk("zero_strobe_mem", dmem[3], 32'h0000BE00);

    // back-to-back reads from m0 alone
    for (int i = 1; i <= 3; i++) bq0.push_back(mk(1'b0, 1'b0, 1'b0, i, 32'd0, 4'hF));
    drain();

    // randomized mixed traffic
    for (int i = 0; i < 200; i++) begin
      for (int n = 0; n < 2; n++) begin
        beat_t b;
        b.bubble = ($urandom_range(0, 4) == 0);
        b.we     = $urandom_range(0, 1);
        b.lock   = !b.bubble && ($urandom_range(0, 3) == 0);
        b.addr   = AW'($urandom_range(0, 15));
        b.wdata  = $urandom;
        b.wstrb  = SW'($urandom_range(0, 15));
        if (n == 0) bq0.push_back(b);
        else bq1.push_back(b);
      end
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
